// File: rtl/div_result_writeback_if.sv
// Divider-to-writeback result handshake: quotient/remainder pair plus control, valid/ready.
interface div_result_writeback_if #(
  parameter int DATA_W = 4,
  parameter int REG_AW = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              div_zero;
  logic [REG_AW-1:0] rd;

  modport master (
    output in_valid, quotient, remainder, div_zero, rd,
    input  in_ready
  );

  modport slave (
    input  in_valid, quotient, remainder, div_zero, rd,
    output in_ready
  );
endinterface

// File: rtl/div_result_writeback.sv
// Divider writeback: 2-entry result FIFO feeding the RF write port (q -> rd, r -> rd+1), 2 cycles/result, 1 for div-by-zero.
// Latency: quotient written one edge after acceptance; in_ready drops while both entries are held (no pass-through).
module div_result_writeback #(
  parameter int DATA_W = 4,
  parameter int RF_W   = 8,
  parameter int REG_AW = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  div_result_writeback_if.slave in_if,
  input  logic                 clr_dz,
  output logic                 wb_we,
  output logic [REG_AW-1:0]    wb_addr,
  output logic [RF_W-1:0]      wb_data,
  output logic                 wb_done,
  output logic                 flag_z,
  output logic                 flag_dz,
  output logic                 busy
);

  typedef struct packed {
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    logic              dz;
    logic [REG_AW-1:0] rd;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WR_Q, WR_R, DZ} state_t;

  state_t     state, state_nxt;
  entry_t     fifo_mem [2];
  entry_t     head, in_ent;
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;
  logic       push, pop;
  logic       nxt_avail, nxt_dz;

  always_comb begin
    in_ent = '{q: in_if.quotient, r: in_if.remainder, dz: in_if.div_zero, rd: in_if.rd};
  end

  assign in_if.in_ready = (count < 2'd2);
  assign push           = in_if.in_valid && in_if.in_ready;
  assign pop            = (state == WR_R) || (state == DZ);
  assign head           = fifo_mem[rd_ptr];
  assign busy           = (count != 2'd0) || (state != IDLE);

  // Head for the next cycle: an entry pushed into an otherwise-empty FIFO is
  // steered straight into the decision so back-to-back results see no bubble.
  always_comb begin
    nxt_avail = 1'b0;
    nxt_dz    = 1'b0;
    if (state == IDLE) begin
      nxt_avail = (count != 2'd0) || push;
      nxt_dz    = (count != 2'd0) ? head.dz : in_ent.dz;
    end else begin
      nxt_avail = (count == 2'd2) || push;
      nxt_dz    = (count == 2'd2) ? fifo_mem[~rd_ptr].dz : in_ent.dz;
    end
  end

  always_comb begin
    state_nxt = state;
    wb_we     = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    wb_done   = 1'b0;
    case (state)
      IDLE: begin
        if (nxt_avail) state_nxt = nxt_dz ? DZ : WR_Q;
      end
      WR_Q: begin
        wb_we     = 1'b1;
        wb_addr   = head.rd;
        wb_data   = RF_W'(head.q);
        state_nxt = WR_R;
      end
      WR_R: begin
        wb_we     = 1'b1;
        wb_addr   = head.rd + REG_AW'(1);
        wb_data   = RF_W'(head.r);
        wb_done   = 1'b1;
        state_nxt = !nxt_avail ? IDLE : (nxt_dz ? DZ : WR_Q);
      end
      DZ: begin
        wb_done   = 1'b1;
        state_nxt = !nxt_avail ? IDLE : (nxt_dz ? DZ : WR_Q);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      flag_z  <= 1'b0;
      flag_dz <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (push) begin
        fifo_mem[wr_ptr] <= in_ent;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (state == WR_Q) flag_z <= (head.q == '0);
      // Set beats clear when both land on the same edge.
      if (state == DZ)   flag_dz <= 1'b1;
      else if (clr_dz)   flag_dz <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_result_writeback.sv
// Directed bench for div_result_writeback: reset, single/wrap, streaming, div-by-zero, reset mid-operation.
module tb_div_result_writeback;
  logic       clk = 1'b0;
  logic       reset;
  logic       clr_dz;
  logic       wb_we;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       wb_done, flag_z, flag_dz, busy;

  div_result_writeback_if #(.DATA_W(4), .REG_AW(3)) in_if ();

  div_result_writeback #(.DATA_W(4), .RF_W(8), .REG_AW(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_if   (in_if),
    .clr_dz  (clr_dz),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .wb_done (wb_done),
    .flag_z  (flag_z),
    .flag_dz (flag_dz),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  logic [3:0] s_q [8];
  logic [3:0] s_r [8];
  logic       s_dz [8];
  logic [2:0] s_rd [8];
  int         s_acc;

  logic       rec_we [16];
  logic [2:0] rec_addr [16];
  logic [7:0] rec_data [16];
  logic       rec_done [16];
  logic       rec_fdz [16];

  logic       e_we [8];
  logic [2:0] e_addr [8];
  logic [7:0] e_data [8];
  logic       e_done [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] q, input logic [3:0] r,
                       input logic dz, input logic [2:0] rd);
    in_if.in_valid  = v;
    in_if.quotient  = q;
    in_if.remainder = r;
    in_if.div_zero  = dz;
    in_if.rd        = rd;
  endtask

  // Offer s_* entries in order, holding in_valid until each is taken; record outputs every cycle.
  task automatic stream(input int n, input int ncyc);
    int   idx;
    logic acc;
    idx = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (idx < n) drive(1'b1, s_q[idx], s_r[idx], s_dz[idx], s_rd[idx]);
      else         drive(1'b0, 4'h0, 4'h0, 1'b0, 3'h0);
      acc = in_if.in_valid && in_if.in_ready;
      step();
      if (acc) idx++;
      if (acc && idx == 2) chk("ready_drop_after_2nd", in_if.in_ready, 1'b0);
      rec_we[c]   = wb_we;
      rec_addr[c] = wb_addr;
      rec_data[c] = wb_data;
      rec_done[c] = wb_done;
      rec_fdz[c]  = flag_dz;
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0, 3'h0);
    s_acc = idx;
  endtask

  // Compare the recorded window against e_* starting at the first write cycle.
  task automatic check_seq(input string tag, input int len, input int ncyc, output int f);
    f = -1;
    for (int c = 0; c < ncyc; c++) if (f < 0 && rec_we[c]) f = c;
    chk($sformatf("%s_first_write_found", tag), f >= 0, 1'b1);
    if (f >= 0 && f + len <= ncyc) begin
      for (int k = 0; k < len; k++) begin
        chk($sformatf("%s_we%0d", tag, k),   rec_we[f+k],   e_we[k]);
        chk($sformatf("%s_addr%0d", tag, k), rec_addr[f+k], e_addr[k]);
        chk($sformatf("%s_data%0d", tag, k), rec_data[f+k], e_data[k]);
        chk($sformatf("%s_done%0d", tag, k), rec_done[f+k], e_done[k]);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, in_if.in_ready, 1'b1);
    chk({tag, "_wb_we"},    wb_we,   1'b0);
    chk({tag, "_wb_addr"},  wb_addr, 3'h0);
    chk({tag, "_wb_data"},  wb_data, 8'h00);
    chk({tag, "_wb_done"},  wb_done, 1'b0);
    chk({tag, "_busy"},     busy,    1'b0);
  endtask

  initial begin
    int f;
    int nwr;
    reset  = 1'b1;
    clr_dz = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 1'b0, 3'h0);

    // Reset held for two cycles
    step();
    step();
    check_idle("rst");
    chk("rst_flag_z",  flag_z,  1'b0);
    chk("rst_flag_dz", flag_dz, 1'b0);
    reset = 1'b0;
    step();
    check_idle("post_rst");

    // Single result 7/2: q=3 r=1 rd=2
    drive(1'b1, 4'd3, 4'd1, 1'b0, 3'd2);
    step();
    drive(1'b0, 4'h0, 4'h0, 1'b0, 3'h0);
    chk("single_q_we",   wb_we,   1'b1);
    chk("single_q_addr", wb_addr, 3'd2);
    chk("single_q_data", wb_data, 8'h03);
    chk("single_q_done", wb_done, 1'b0);
    chk("single_busy",   busy,    1'b1);
    step();
    chk("single_r_we",   wb_we,   1'b1);
    chk("single_r_addr", wb_addr, 3'd3);
    chk("single_r_data", wb_data, 8'h01);
    chk("single_r_done", wb_done, 1'b1);
    step();
    check_idle("single_end");
    chk("single_flag_z", flag_z, 1'b0);

    // Zero quotient and rd=7 wrap
    drive(1'b1, 4'd0, 4'd5, 1'b0, 3'd7);
    step();
    drive(1'b0, 4'h0, 4'h0, 1'b0, 3'h0);
    chk("wrap_q_addr", wb_addr, 3'd7);
    chk("wrap_q_data", wb_data, 8'h00);
    chk("wrap_q_we",   wb_we,   1'b1);
    step();
    chk("wrap_r_addr", wb_addr, 3'd0);
    chk("wrap_r_data", wb_data, 8'h05);
    chk("wrap_r_done", wb_done, 1'b1);
    chk("wrap_flag_z", flag_z,  1'b1);
    step();
    chk("wrap_flag_z_held", flag_z, 1'b1);
    chk("wrap_busy",        busy,   1'b0);

    // Back-to-back: three normal results to rd 0, 2, 4
    s_q[0] = 4'd9; s_r[0] = 4'd2;  s_dz[0] = 1'b0; s_rd[0] = 3'd0;
    s_q[1] = 4'd3; s_r[1] = 4'd12; s_dz[1] = 1'b0; s_rd[1] = 3'd2;
    s_q[2] = 4'd5; s_r[2] = 4'd0;  s_dz[2] = 1'b0; s_rd[2] = 3'd4;
    e_we   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    e_addr = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0};
    e_data = '{8'd9, 8'd2, 8'd3, 8'd12, 8'd5, 8'd0, 8'd0, 8'd0};
    e_done = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    stream(3, 12);
    chk("b2b_accepted", s_acc, 3);
    check_seq("b2b", 7, 12, f);
    chk("b2b_flag_z", flag_z, 1'b0);
    chk("b2b_idle",   busy,   1'b0);

    // Divide-by-zero between two normal results
    s_q[0] = 4'd6; s_r[0] = 4'd3; s_dz[0] = 1'b0; s_rd[0] = 3'd1;
    s_q[1] = 4'd7; s_r[1] = 4'd7; s_dz[1] = 1'b1; s_rd[1] = 3'd4;
    s_q[2] = 4'd2; s_r[2] = 4'd1; s_dz[2] = 1'b0; s_rd[2] = 3'd5;
    e_we   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    e_addr = '{3'd1, 3'd2, 3'd0, 3'd5, 3'd6, 3'd0, 3'd0, 3'd0};
    e_data = '{8'd6, 8'd3, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    e_done = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    stream(3, 12);
    chk("dz_accepted", s_acc, 3);
    check_seq("dz", 6, 12, f);
    if (f >= 0) begin
      chk("dz_flag_during_dz", rec_fdz[f+2], 1'b0);
      chk("dz_flag_after_dz",  rec_fdz[f+3], 1'b1);
    end
    step();
    chk("dz_flag_sticky", flag_dz, 1'b1);
    clr_dz = 1'b1;
    step();
    clr_dz = 1'b0;
    chk("dz_flag_cleared", flag_dz, 1'b0);

    // Set beats clear: clr_dz held across a lone DZ entry
    clr_dz = 1'b1;
    drive(1'b1, 4'd1, 4'd1, 1'b1, 3'd4);
    step();
    drive(1'b0, 4'h0, 4'h0, 1'b0, 3'h0);
    chk("dzclr_we",   wb_we,   1'b0);
    chk("dzclr_done", wb_done, 1'b1);
    step();
    chk("dzclr_set_wins", flag_dz, 1'b1);
    chk("dzclr_no_done",  wb_done, 1'b0);
    step();
    chk("dzclr_cleared_after", flag_dz, 1'b0);
    clr_dz = 1'b0;

    // Reset while writing a quotient, with another result being offered
    drive(1'b1, 4'd4, 4'd2, 1'b0, 3'd3);
    step();
    chk("rstmid_q_we",   wb_we,   1'b1);
    chk("rstmid_q_addr", wb_addr, 3'd3);
    drive(1'b1, 4'd8, 4'd1, 1'b0, 3'd6);
    reset = 1'b1;
    step();
    drive(1'b0, 4'h0, 4'h0, 1'b0, 3'h0);
    check_idle("rstmid");
    reset = 1'b0;
    nwr = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (wb_we) nwr++;
    end
    chk("rstmid_no_late_write", nwr, 0);
    chk("rstmid_busy_end",      busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
